// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus target.
//   state_e     : access FSM states (idle, inserting wait states, active)
//   REG_*       : I/O register offsets within the 4-port I/O window
//   CTRL_IRQ_EN : bit position of the interrupt enable in CTRL
package z80_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic [1:0] REG_SCRATCH = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_VECTOR  = 2'd3;

  localparam int CTRL_IRQ_EN = 0;

endpackage

// File: rtl/z80_bus_target_if.sv
// Z80 bus as seen between the CPU wrapper and a bus target.
//   master : CPU side, drives strobes, address and write data
//   slave  : target side, returns read data, select, wait and interrupt
interface z80_bus_target_if;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        rfsh_n;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic [7:0]  di;
  logic        sel;
  logic        wait_n;
  logic        int_n;

  modport master (
    output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, cpu_dout,
    input  di, sel, wait_n, int_n
  );

  modport slave (
    input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, cpu_dout,
    output di, sel, wait_n, int_n
  );
endinterface

// File: rtl/z80_target_ram.sv
// Local RAM of the bus target: 2^AW x 8 register array.
//   clk   : clock
//   we    : write enable (already qualified with cen and access commit)
//   addr  : byte address inside the window
//   wdata : write data
//   rdata : asynchronous read data at addr
module z80_target_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [2**AW];

  // NOTE: the array has no reset on purpose; RAM contents are undefined after
  // power-up and a reset term would turn the array into plain flops with muxes.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/z80_bus_target.sv
// Memory- and I/O-mapped responder on the Z80 bus.
//   clk, reset_n : clock, synchronous active-low reset
//   cen          : clock enable shared with the CPU; state moves only when 1
//   irq_in       : level-sensitive peripheral interrupt source
//   ctrl_q       : CTRL register contents
//   bus          : Z80 bus (slave side): strobes, A, cpu_dout in;
//                  di, sel, wait_n, int_n out
// Serves a RAM window at MEM_BASE, four I/O registers at IO_BASE and an IM2
// vector during interrupt acknowledge, inserting WAIT_CYCLES wait states.
module z80_bus_target
  import z80_bus_pkg::*;
#(
  parameter logic [15:0] MEM_BASE    = 16'h8000,
  parameter int          MEM_AW      = 8,
  parameter logic [7:0]  IO_BASE     = 8'h40,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cen,
  input  logic              irq_in,
  output logic [7:0]        ctrl_q,
  z80_bus_target_if.slave   bus
);

  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] scratch_q, scratch_d;
  logic [7:0] ctrl_d;
  logic [7:0] vector_q, vector_d;
  logic       pending_q, pending_d;
  logic       int_n_q, int_n_d;

  logic       mem_hit, io_hit, inta, hit;
  logic       rd_access, wr_access, strobes_idle;
  logic       at_active, commit_ok, wr_commit, inta_clr;
  logic       io_wr, pending_set, pending_clr;
  logic [1:0] reg_off;
  logic [7:0] ram_rdata, io_rdata, di_mux;

  // Decode is gated by reset so nothing is selected, waited on or written
  // while the block is held in reset, even if the CPU still drives strobes.
  always_comb begin
    mem_hit      = reset_n && !bus.mreq_n && bus.rfsh_n &&
                   (bus.A[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
    io_hit       = reset_n && !bus.iorq_n && bus.m1_n &&
                   (bus.A[7:2] == IO_BASE[7:2]);
    inta         = reset_n && !bus.iorq_n && !bus.m1_n;
    hit          = mem_hit || io_hit || inta;
    rd_access    = hit && !bus.rd_n;
    wr_access    = (mem_hit || io_hit) && !bus.wr_n;
    strobes_idle = bus.rd_n && bus.wr_n && bus.mreq_n && bus.iorq_n;
    reg_off      = bus.A[1:0];
  end

  // FSM next state and per-access commit.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;

    // With no wait states the detection tick itself is the first active tick.
    at_active = (state_q == ST_ACTIVE) ||
                ((state_q == ST_IDLE) && hit && !HAS_WAIT);
    commit_ok = cen && at_active && !done_q;
    wr_commit = commit_ok && wr_access;
    inta_clr  = commit_ok && inta;

    if (cen) begin
      unique case (state_q)
        ST_IDLE: begin
          if (hit) begin
            if (HAS_WAIT) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_INIT;
            end else begin
              state_d = ST_ACTIVE;
            end
          end
        end
        ST_WAIT: begin
          if (strobes_idle)        state_d = ST_IDLE;   // aborted cycle
          else if (cnt_q == 4'd0)  state_d = ST_ACTIVE;
          else                     cnt_d   = cnt_q - 4'd1;
        end
        ST_ACTIVE: begin
          if (strobes_idle) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // done blocks a second commit until the access ends.
    if (wr_commit || inta_clr) done_d = 1'b1;
    if (state_d == ST_IDLE)    done_d = 1'b0;
  end

  // I/O registers and interrupt state.
  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    vector_d  = vector_q;

    io_wr = wr_commit && io_hit;
    if (io_wr) begin
      unique case (reg_off)
        REG_SCRATCH: scratch_d = bus.cpu_dout;
        REG_CTRL:    ctrl_d    = bus.cpu_dout;
        REG_VECTOR:  vector_d  = bus.cpu_dout;
        default:     ;
      endcase
    end

    pending_set = cen && irq_in && ctrl_q[CTRL_IRQ_EN];
    pending_clr = inta_clr ||
                  (io_wr && (reg_off == REG_STATUS) && bus.cpu_dout[0]);
    // A new request in the same tick as a clear must not be lost.
    if (pending_set)      pending_d = 1'b1;
    else if (pending_clr) pending_d = 1'b0;
    else                  pending_d = pending_q;

    int_n_d = cen ? ~(pending_q & ctrl_q[CTRL_IRQ_EN]) : int_n_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      done_q    <= 1'b0;
      scratch_q <= 8'h00;
      ctrl_q    <= 8'h00;
      vector_q  <= 8'hFF;
      pending_q <= 1'b0;
      int_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      vector_q  <= vector_d;
      pending_q <= pending_d;
      int_n_q   <= int_n_d;
    end
  end

  z80_target_ram #(
    .AW (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_commit && mem_hit),
    .addr  (bus.A[MEM_AW-1:0]),
    .wdata (bus.cpu_dout),
    .rdata (ram_rdata)
  );

  // Read path is combinational so data is valid as soon as the read decodes.
  always_comb begin
    unique case (reg_off)
      REG_SCRATCH: io_rdata = scratch_q;
      REG_CTRL:    io_rdata = ctrl_q;
      REG_STATUS:  io_rdata = {6'b0, irq_in, pending_q};
      default:     io_rdata = vector_q;
    endcase

    if (!rd_access)   di_mux = 8'hFF;
    else if (inta)    di_mux = vector_q;
    else if (mem_hit) di_mux = ram_rdata;
    else              di_mux = io_rdata;
  end

  assign bus.di     = di_mux;
  assign bus.sel    = rd_access;
  assign bus.wait_n = !(((state_q == ST_IDLE) && hit && HAS_WAIT) ||
                        (state_q == ST_WAIT));
  assign bus.int_n  = int_n_q;

endmodule
